// File: rtl/wb_pkg.sv
// Shared write-back definitions: register address width, default data width
// and the queued entry layout.
package wb_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Write-back entry storage with wrapping pointers; exposes entries in age order
// (index 0 = head). WB_QUEUE_BYPASS_EN adds the per-entry data view.
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int unsigned DEPTH  = 4,
  parameter  int unsigned DATA_W = wb_pkg::DATA_W,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned CNT_W  = PTR_W + 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_push,
  input  logic                                 i_pop,
  input  logic [REG_ADDR_W-1:0]                i_rd,
  input  logic [DATA_W-1:0]                    i_data,
  output logic [CNT_W-1:0]                     o_count,
  output logic [DEPTH-1:0]                     o_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]     o_rd,
  output logic [DATA_W-1:0]                    o_head_data
`ifdef WB_QUEUE_BYPASS_EN
  ,
  output logic [DEPTH-1:0][DATA_W-1:0]         o_data
`endif
);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } entry_t;

  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [PTR_W-1:0]   w_idx;

  // Pointers are exactly log2(DEPTH) bits, so increments wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= '{rd: i_rd, data: i_data};
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    o_valid = '0;
    o_rd    = '0;
    w_idx   = '0;
`ifdef WB_QUEUE_BYPASS_EN
    o_data  = '0;
`endif
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_idx      = r_rd_ptr + PTR_W'(k);
      o_valid[k] = (CNT_W'(k) < r_count);
      o_rd[k]    = r_mem[w_idx].rd;
`ifdef WB_QUEUE_BYPASS_EN
      o_data[k]  = r_mem[w_idx].data;
`endif
    end
  end

  assign o_head_data = r_mem[r_rd_ptr].data;
  assign o_count     = r_count;

endmodule

// File: rtl/wb_queue.sv
// Write-back queue in front of the register-file write port, with pending-write
// hazard lookup. WB_QUEUE_BYPASS_EN adds fwdDataA/fwdDataB forwarding outputs.
module wb_queue
  import wb_pkg::*;
#(
  parameter  int unsigned DEPTH  = 4,
  parameter  int unsigned DATA_W = wb_pkg::DATA_W,
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [REG_ADDR_W-1:0] inReg,
  input  logic [DATA_W-1:0]     inData,
  input  logic                  wbStall,
  output logic [REG_ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0]     writeData,
  output logic                  RegWrite,
  input  logic [REG_ADDR_W-1:0] lookRegA,
  input  logic [REG_ADDR_W-1:0] lookRegB,
  output logic                  hazardA,
  output logic                  hazardB,
  output logic [CNT_W-1:0]      count
`ifdef WB_QUEUE_BYPASS_EN
  ,
  output logic [DATA_W-1:0]     fwdDataA,
  output logic [DATA_W-1:0]     fwdDataB
`endif
);

  logic [CNT_W-1:0]                 w_count;
  logic [DEPTH-1:0]                 w_valid;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] w_rd;
  logic [DATA_W-1:0]                w_head_data;
  logic                             w_push;
  logic                             w_pop;
  logic [1:0][REG_ADDR_W-1:0]       w_look;
  logic [1:0]                       w_hit;
`ifdef WB_QUEUE_BYPASS_EN
  logic [DEPTH-1:0][DATA_W-1:0]     w_data;
  logic [1:0][DATA_W-1:0]           w_fwd;
`endif

  logic                  r_reg_write;
  logic [REG_ADDR_W-1:0] r_write_reg;
  logic [DATA_W-1:0]     r_write_data;

  // Register 0 writes are accepted (handshake completes) but never stored.
  assign inReady = (w_count < CNT_W'(DEPTH));
  assign w_push  = inValid && inReady && (inReg != '0);
  assign w_pop   = (w_count != '0) && !wbStall;

  wb_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_rd        (inReg),
    .i_data      (inData),
    .o_count     (w_count),
    .o_valid     (w_valid),
    .o_rd        (w_rd),
    .o_head_data (w_head_data)
`ifdef WB_QUEUE_BYPASS_EN
    ,
    .o_data      (w_data)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_reg_write  <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
    end else begin
      r_reg_write <= w_pop;
      if (w_pop) begin
        r_write_reg  <= w_rd[0];
        r_write_data <= w_head_data;
      end
    end
  end

  assign w_look = {lookRegB, lookRegA};

  // Scan oldest (write port) to youngest so the last match wins the forward.
  always_comb begin
    w_hit = '0;
`ifdef WB_QUEUE_BYPASS_EN
    w_fwd = '0;
`endif
    for (int unsigned p = 0; p < 2; p++) begin
      if (w_look[p] != '0) begin
        if (r_reg_write && (r_write_reg == w_look[p])) begin
          w_hit[p] = 1'b1;
`ifdef WB_QUEUE_BYPASS_EN
          w_fwd[p] = r_write_data;
`endif
        end
        for (int unsigned k = 0; k < DEPTH; k++) begin
          if (w_valid[k] && (w_rd[k] == w_look[p])) begin
            w_hit[p] = 1'b1;
`ifdef WB_QUEUE_BYPASS_EN
            w_fwd[p] = w_data[k];
`endif
          end
        end
      end
    end
  end

  assign hazardA   = w_hit[0];
  assign hazardB   = w_hit[1];
  assign RegWrite  = r_reg_write;
  assign writeReg  = r_write_reg;
  assign writeData = r_write_data;
  assign count     = w_count;
`ifdef WB_QUEUE_BYPASS_EN
  assign fwdDataA  = w_fwd[0];
  assign fwdDataB  = w_fwd[1];
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Randomized + directed bench for wb_queue with a queue-based reference model
// and a write-port scoreboard.
module tb_wb_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [4:0]  inReg = '0;
  logic [31:0] inData = '0;
  logic        wbStall = 1'b0;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic        RegWrite;
  logic [4:0]  lookRegA = '0;
  logic [4:0]  lookRegB = '0;
  logic        hazardA;
  logic        hazardB;
  logic [2:0]  count;
`ifdef WB_QUEUE_BYPASS_EN
  logic [31:0] fwdDataA;
  logic [31:0] fwdDataB;
`endif

  always #5 clk = ~clk;

  wb_queue #(.DEPTH(DEPTH), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .inValid   (inValid),
    .inReady   (inReady),
    .inReg     (inReg),
    .inData    (inData),
    .wbStall   (wbStall),
    .writeReg  (writeReg),
    .writeData (writeData),
    .RegWrite  (RegWrite),
    .lookRegA  (lookRegA),
    .lookRegB  (lookRegB),
    .hazardA   (hazardA),
    .hazardB   (hazardB),
    .count     (count)
`ifdef WB_QUEUE_BYPASS_EN
    ,
    .fwdDataA  (fwdDataA),
    .fwdDataB  (fwdDataB)
`endif
  );

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];      // model of pending queue contents, oldest first
  ent_t        sb[$];      // expected register-file writes, in order
  bit          m_rw = 1'b0;
  logic [4:0]  m_wreg = '0;
  logic [31:0] m_wdata = '0;
  bit          m_known = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_haz(input logic [4:0] look);
    if (look == 5'd0) return 1'b0;
    if (m_rw && m_wreg == look) return 1'b1;
    foreach (mq[i]) if (mq[i].r == look) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_fwd(input logic [4:0] look);
    logic [31:0] v = '0;
    if (m_rw && m_wreg == look) v = m_wdata;
    foreach (mq[i]) if (mq[i].r == look) v = mq[i].d;
    return v;
  endfunction

  // Scoreboard monitor: every asserted write must match the next expected one.
  always @(negedge clk) begin : mon
    ent_t e;
    if (RegWrite === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL wb_unexpected: got write reg %0d data %0h expected no write", writeReg, writeData);
      end else begin
        e = sb.pop_front();
        chk("wb_reg", 64'(writeReg), 64'(e.r));
        chk("wb_data", 64'(writeData), 64'(e.d));
      end
    end
  end

  task automatic step(input bit v, input logic [4:0] r, input logic [31:0] d,
                      input bit st, input bit rs, input logic [4:0] la, input logic [4:0] lb);
    bit   do_pop;
    bit   do_push;
    ent_t e;
    @(posedge clk);
    #1;
    inValid = v; inReg = r; inData = d; wbStall = st; rst = rs;
    lookRegA = la; lookRegB = lb;
    @(negedge clk);
    #1;
    if (m_known) begin
      chk("count", 64'(count), 64'(mq.size()));
      chk("inReady", 64'(inReady), 64'(mq.size() < DEPTH));
      chk("RegWrite", 64'(RegWrite), 64'(m_rw));
      chk("writeReg", 64'(writeReg), 64'(m_wreg));
      chk("writeData", 64'(writeData), 64'(m_wdata));
      chk("hazardA", 64'(hazardA), 64'(exp_haz(la)));
      chk("hazardB", 64'(hazardB), 64'(exp_haz(lb)));
`ifdef WB_QUEUE_BYPASS_EN
      if (exp_haz(la)) chk("fwdDataA", 64'(fwdDataA), 64'(exp_fwd(la)));
      if (exp_haz(lb)) chk("fwdDataB", 64'(fwdDataB), 64'(exp_fwd(lb)));
`endif
    end
    if (rs) begin
      mq.delete();
      sb.delete();
      m_rw = 1'b0; m_wreg = '0; m_wdata = '0;
      m_known = 1'b1;
    end else begin
      do_pop  = (mq.size() != 0) && !st;
      do_push = v && (mq.size() < DEPTH) && (r != 5'd0);
      m_rw = do_pop;
      if (do_pop) begin
        e = mq.pop_front();
        m_wreg = e.r; m_wdata = e.d;
      end
      if (do_push) begin
        e.r = r; e.d = d;
        mq.push_back(e);
        sb.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n, input logic [4:0] la);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, la, 5'd0);
  endtask

  initial begin
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);

    // Single push to empty queue: write appears after the second edge.
    step(1, 5'd3, 32'h10, 0, 0, 5'd3, 5'd0);
    idle(3, 5'd3);

    // Fill under stall, offer a fifth, then drain in order.
    for (int i = 0; i < 4; i++) step(1, 5'(8 + i), 32'hA0 + 32'(i), 1, 0, 5'd9, 5'd11);
    step(1, 5'd20, 32'hBAD, 1, 0, 5'd20, 5'd8);
    step(0, 0, 0, 1, 0, 5'd10, 5'd0);
    idle(6, 5'd8);

    // Register 0 is accepted and dropped.
    step(1, 5'd0, 32'hFFFF_FFFF, 0, 0, 5'd0, 5'd0);
    idle(3, 5'd0);

    // Two writes to r5: hazard held until the second leaves the write port.
    step(1, 5'd5, 32'h1, 1, 0, 5'd5, 5'd0);
    step(1, 5'd5, 32'h2, 1, 0, 5'd5, 5'd0);
    step(0, 0, 0, 1, 0, 5'd5, 5'd0);
    idle(4, 5'd5);

    // Hold at three entries, then simultaneous push/pop across pointer wrap.
    for (int i = 0; i < 3; i++) step(1, 5'(1 + i), 32'h100 + 32'(i), 1, 0, 5'd2, 5'd0);
    for (int i = 0; i < 7; i++) step(1, 5'(4 + i), 32'h200 + 32'(i), 0, 0, 5'(5 + i), 5'd1);
    step(1, 5'd30, 32'h300, 0, 1, 5'd30, 5'd0);
    idle(4, 5'd30);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 99) < 60,
           5'($urandom_range(0, 7)),
           $urandom,
           $urandom_range(0, 99) < 35,
           $urandom_range(0, 99) < 2,
           5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)));
    end
    idle(8, 5'd0);
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL wb_missing: got %0d writes outstanding expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
